// File: rtl/hand_position_decoder_if.sv
// hand_position_decoder_if: slow timebase inputs, set-load controls and hand-position outputs.
// Latency: none (wires only).
// Backpressure: none; every signal is a level sampled by the decoder each clock.
interface hand_position_decoder_if;
    logic       minuteClock;
    logic       hourClock;
    logic       setEnable;
    logic [5:0] setMinute;
    logic [5:0] setHour;
    logic [5:0] minutePos;
    logic [5:0] hourPos;
    logic       posStrobe;
    logic       syncError;

    // Timebase / set-load source side.
    modport master (
        output minuteClock,
        output hourClock,
        output setEnable,
        output setMinute,
        output setHour,
        input  minutePos,
        input  hourPos,
        input  posStrobe,
        input  syncError
    );

    // Decoder side.
    modport slave (
        input  minuteClock,
        input  hourClock,
        input  setEnable,
        input  setMinute,
        input  setHour,
        output minutePos,
        output hourPos,
        output posStrobe,
        output syncError
    );
endinterface

// File: rtl/hand_position_decoder.sv
// hand_position_decoder: turns the slow minute tick / half-hour toggle into 0..59 hand positions.
// Latency: positions move 2 clocks after minuteClock is first sampled high; a set loads on its own edge.
// Backpressure: none; no handshake, outputs are registered and the strobe is a single-cycle pulse.
// Build option: define HAND_RESYNC_EN to snap the minute hand to 0/30 on a misaligned half-hour event.
module hand_position_decoder #(
    parameter int SUB_STEPS  = 12,
    parameter int DIAL_STEPS = 60
) (
    input  logic                   clock,
    input  logic                   reset,
    hand_position_decoder_if.slave bus
);

    localparam int              SW       = (SUB_STEPS > 1) ? $clog2(SUB_STEPS) : 1;
    localparam logic [5:0]      LAST_POS = 6'(DIAL_STEPS - 1);
    localparam logic [5:0]      HALF_POS = 6'(DIAL_STEPS / 2);
    localparam logic [SW-1:0]   LAST_SUB = SW'(SUB_STEPS - 1);
`ifdef HAND_RESYNC_EN
    localparam logic [SW-1:0]   HALF_SUB = SW'((DIAL_STEPS / 2) % SUB_STEPS);
`endif

    // Synchronizer chains and edge-history flops for both slow inputs.
    logic          min_sync1_q, min_sync2_q, min_hist_q;
    logic          hr_sync1_q, hr_sync2_q, hr_hist_q;
    // Counts the first clocks after reset release; detection is blocked until it saturates.
    logic [1:0]    arm_cnt_q;

    // Architectural state.
    logic [5:0]    minute_pos_q, minute_pos_d;
    logic [5:0]    hour_pos_q, hour_pos_d;
    logic [SW-1:0] hour_sub_q, hour_sub_d;
    logic          phase_q, phase_d;
    logic          sync_err_q, sync_err_d;
    logic          set_chg_q, set_chg_d;
    logic          strobe_q, strobe_d;

    // Decoded events and set-load values.
    logic          armed;
    logic          minute_tick;
    logic          hour_evt;
    logic [5:0]    exp_pos;
    logic          pos_moved;
    logic [5:0]    set_min;
    logic [5:0]    set_hr;
    logic [SW-1:0] set_sub;
    logic          set_phase;

    // Minute input: two flops against metastability, then one flop of history for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            min_sync1_q <= 1'b0;
            min_sync2_q <= 1'b0;
            min_hist_q  <= 1'b0;
        end else begin
            min_sync1_q <= bus.minuteClock;
            min_sync2_q <= min_sync1_q;
            min_hist_q  <= min_sync2_q;
        end
    end

    // Half-hour input: same structure; any level change is an event.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hr_sync1_q <= 1'b0;
            hr_sync2_q <= 1'b0;
            hr_hist_q  <= 1'b0;
        end else begin
            hr_sync1_q <= bus.hourClock;
            hr_sync2_q <= hr_sync1_q;
            hr_hist_q  <= hr_sync2_q;
        end
    end

    // Arming counter: lets the history flops catch up with inputs that were already high at reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            arm_cnt_q <= 2'd0;
        end else if (arm_cnt_q != 2'd3) begin
            arm_cnt_q <= arm_cnt_q + 2'd1;
        end
    end

    assign armed       = (arm_cnt_q == 2'd3);
    assign minute_tick = armed & min_sync2_q & ~min_hist_q;
    assign hour_evt    = armed & (hr_sync2_q ^ hr_hist_q);

    // Set-load values: positions clamp to the last dial step, sub-step and phase derive from the minute.
    assign set_min   = (bus.setMinute > LAST_POS) ? LAST_POS : bus.setMinute;
    assign set_hr    = (bus.setHour   > LAST_POS) ? LAST_POS : bus.setHour;
    assign set_sub   = SW'(32'(set_min) % SUB_STEPS);
    assign set_phase = (set_min >= HALF_POS);

    // Next-state: tick increment first, then the half-hour alignment check; a set overrides both.
    always_comb begin
        minute_pos_d = minute_pos_q;
        hour_pos_d   = hour_pos_q;
        hour_sub_d   = hour_sub_q;
        phase_d      = phase_q;
        sync_err_d   = sync_err_q;
        set_chg_d    = 1'b0;
        pos_moved    = 1'b0;
        exp_pos      = phase_q ? 6'd0 : HALF_POS;

        if (minute_tick) begin
            minute_pos_d = (minute_pos_q == LAST_POS) ? 6'd0 : minute_pos_q + 6'd1;
            if (hour_sub_q == LAST_SUB) begin
                hour_sub_d = '0;
                hour_pos_d = (hour_pos_q == LAST_POS) ? 6'd0 : hour_pos_q + 6'd1;
            end else begin
                hour_sub_d = hour_sub_q + SW'(1);
            end
        end

        if (hour_evt) begin
            phase_d = ~phase_q;
            // Compare against the minute value including any tick taken this cycle.
            if (minute_pos_d != exp_pos) begin
                sync_err_d = 1'b1;
`ifdef HAND_RESYNC_EN
                minute_pos_d = exp_pos;
                hour_sub_d   = phase_q ? '0 : HALF_SUB;
`endif
            end
        end

        pos_moved = (minute_pos_d != minute_pos_q) || (hour_pos_d != hour_pos_q);

        if (bus.setEnable) begin
            minute_pos_d = set_min;
            hour_pos_d   = set_hr;
            hour_sub_d   = set_sub;
            phase_d      = set_phase;
            sync_err_d   = 1'b0;
            // A set strobes one edge after the load, and only if something actually moved.
            set_chg_d    = (set_min != minute_pos_q) || (set_hr != hour_pos_q);
            pos_moved    = 1'b0;
        end

        strobe_d = pos_moved | set_chg_q;
    end

    // State register for hand positions, dial phase, error flag and strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            minute_pos_q <= 6'd0;
            hour_pos_q   <= 6'd0;
            hour_sub_q   <= '0;
            phase_q      <= 1'b0;
            sync_err_q   <= 1'b0;
            set_chg_q    <= 1'b0;
            strobe_q     <= 1'b0;
        end else begin
            minute_pos_q <= minute_pos_d;
            hour_pos_q   <= hour_pos_d;
            hour_sub_q   <= hour_sub_d;
            phase_q      <= phase_d;
            sync_err_q   <= sync_err_d;
            set_chg_q    <= set_chg_d;
            strobe_q     <= strobe_d;
        end
    end

    assign bus.minutePos = minute_pos_q;
    assign bus.hourPos   = hour_pos_q;
    assign bus.posStrobe = strobe_q;
    assign bus.syncError = sync_err_q;

endmodule

// File: tb/tb_hand_position_decoder.sv
// tb_hand_position_decoder: directed stimulus with a reference model feeding an expected-strobe queue.
// Latency: each strobe is matched against the oldest queued expected hand position.
// Backpressure: none; the bench drives levels and observes on the falling clock edge.
module tb_hand_position_decoder;

    logic clock = 1'b0;
    logic reset;

    hand_position_decoder_if bus ();

    hand_position_decoder #(
        .SUB_STEPS (12),
        .DIAL_STEPS(60)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [5:0] m;
        logic [5:0] h;
    } pos_t;

    int   ncheck = 0;
    int   npass  = 0;
    pos_t exp_q[$];
    pos_t mon_e;

    // Reference model state.
    int mm, mh, msub;
    bit mphase, merr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncheck++;
        assert (got === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_clear();
        mm = 0; mh = 0; msub = 0; mphase = 1'b0; merr = 1'b0;
        exp_q.delete();
    endtask

    // Applies a minute tick and/or half-hour event to the model; queues an expected strobe on movement.
    task automatic model_step(input bit tk, input bit ev);
        int om = mm;
        int oh = mh;
        int e;
        if (tk) begin
            mm = (mm + 1) % 60;
            if (msub == 11) begin
                msub = 0;
                mh   = (mh + 1) % 60;
            end else begin
                msub++;
            end
        end
        if (ev) begin
            e = mphase ? 0 : 30;
            if (mm != e) begin
                merr = 1'b1;
`ifdef HAND_RESYNC_EN
                mm   = e;
                msub = e % 12;
`endif
            end
            mphase = ~mphase;
        end
        if (mm != om || mh != oh) exp_q.push_back({6'(mm), 6'(mh)});
    endtask

    task automatic model_set(input int sm, input int sh);
        int om = mm;
        int oh = mh;
        mm     = (sm > 59) ? 59 : sm;
        mh     = (sh > 59) ? 59 : sh;
        msub   = mm % 12;
        mphase = (mm >= 30);
        merr   = 1'b0;
        if (mm != om || mh != oh) exp_q.push_back({6'(mm), 6'(mh)});
    endtask

    // Called just after a falling edge; holds each level for at least 3 clocks.
    task automatic pulse(input bit tk, input bit ev);
        model_step(tk, ev);
        if (tk) bus.minuteClock = 1'b1;
        if (ev) bus.hourClock = ~bus.hourClock;
        repeat (3) @(negedge clock);
        if (tk) begin
            bus.minuteClock = 1'b0;
            repeat (3) @(negedge clock);
        end
    endtask

    task automatic set_pulse(input int sm, input int sh);
        bus.setMinute = 6'(sm);
        bus.setHour   = 6'(sh);
        bus.setEnable = 1'b1;
        model_set(sm, sh);
        @(negedge clock);
        bus.setEnable = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_clear();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    // Every strobe must match the oldest expected position; a strobe with nothing queued is spurious.
    always @(negedge clock) begin
        if (bus.posStrobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("strobe_minutePos", 32'(bus.minutePos), 32'(mon_e.m));
                chk("strobe_hourPos", 32'(bus.hourPos), 32'(mon_e.h));
            end
        end
    end

    initial begin
        bus.minuteClock = 1'b1;
        bus.hourClock   = 1'b0;
        bus.setEnable   = 1'b0;
        bus.setMinute   = 6'd0;
        bus.setHour     = 6'd0;
        reset           = 1'b1;
        model_clear();
        repeat (2) @(negedge clock);

        // Reset state, with minuteClock already high.
        chk("rst_minutePos", 32'(bus.minutePos), 32'd0);
        chk("rst_hourPos", 32'(bus.hourPos), 32'd0);
        chk("rst_posStrobe", 32'(bus.posStrobe), 32'd0);
        chk("rst_syncError", 32'(bus.syncError), 32'd0);
        reset = 1'b0;

        // Arming: a level that is high at release must not count as a tick.
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("arm_minutePos", 32'(bus.minutePos), 32'd0);
            chk("arm_posStrobe", 32'(bus.posStrobe), 32'd0);
        end
        bus.minuteClock = 1'b0;
        repeat (3) @(negedge clock);

        // First real edge: sampled at k, positions and strobe at k+2, strobe gone at k+3.
        model_step(1'b1, 1'b0);
        bus.minuteClock = 1'b1;
        @(negedge clock);
        @(negedge clock);
        chk("lat_k1_minutePos", 32'(bus.minutePos), 32'd0);
        chk("lat_k1_posStrobe", 32'(bus.posStrobe), 32'd0);
        @(negedge clock);
        chk("lat_k2_minutePos", 32'(bus.minutePos), 32'd1);
        chk("lat_k2_posStrobe", 32'(bus.posStrobe), 32'd1);
        @(negedge clock);
        chk("lat_k3_posStrobe", 32'(bus.posStrobe), 32'd0);
        bus.minuteClock = 1'b0;
        repeat (3) @(negedge clock);

        // Full 12-hour revolution with aligned half-hour toggles.
        do_reset();
        for (int i = 1; i <= 720; i++) begin
            pulse(1'b1, (i % 30) == 0);
            if (i % 12 == 0) chk("carry_hourPos", 32'(bus.hourPos), 32'((i / 12) % 60));
            if (i == 30) chk("aligned30_syncError", 32'(bus.syncError), 32'd0);
            if (i == 60) begin
                chk("aligned60_syncError", 32'(bus.syncError), 32'd0);
                chk("tick60_hourPos", 32'(bus.hourPos), 32'd5);
                chk("tick60_minutePos", 32'(bus.minutePos), 32'd0);
            end
        end
        chk("wrap_minutePos", 32'(bus.minutePos), 32'd0);
        chk("wrap_hourPos", 32'(bus.hourPos), 32'd0);
        chk("wrap_syncError", 32'(bus.syncError), 32'd0);

        // Misaligned half-hour event after tick 28.
        do_reset();
        for (int i = 0; i < 28; i++) pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        chk("misalign_syncError", 32'(bus.syncError), 32'd1);
`ifdef HAND_RESYNC_EN
        chk("misalign_minutePos", 32'(bus.minutePos), 32'd30);
`else
        chk("misalign_minutePos", 32'(bus.minutePos), 32'd28);
`endif
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
        chk("misalign_5_hourPos", 32'(bus.hourPos), 32'd2);
        pulse(1'b1, 1'b0);
`ifdef HAND_RESYNC_EN
        chk("misalign_6_hourPos", 32'(bus.hourPos), 32'd3);
        chk("misalign_6_minutePos", 32'(bus.minutePos), 32'd36);
`else
        chk("misalign_6_hourPos", 32'(bus.hourPos), 32'd2);
        chk("misalign_6_minutePos", 32'(bus.minutePos), 32'd34);
`endif
        chk("misalign_sticky", 32'(bus.syncError), 32'd1);

        // Set in the same cycle the minute tick is detected: set wins, tick is dropped.
        bus.setMinute   = 6'd63;
        bus.setHour     = 6'd17;
        bus.minuteClock = 1'b1;
        @(negedge clock);
        @(negedge clock);
        bus.setEnable = 1'b1;
        model_set(63, 17);
        @(negedge clock);
        bus.setEnable = 1'b0;
        chk("set_minutePos", 32'(bus.minutePos), 32'd59);
        chk("set_hourPos", 32'(bus.hourPos), 32'd17);
        chk("set_syncError", 32'(bus.syncError), 32'd0);
        @(negedge clock);
        bus.minuteClock = 1'b0;
        repeat (3) @(negedge clock);
        chk("set_tick_dropped", 32'(bus.minutePos), 32'd59);
        pulse(1'b1, 1'b0);
        chk("post_set_minutePos", 32'(bus.minutePos), 32'd0);
        chk("post_set_hourPos", 32'(bus.hourPos), 32'd18);
        // Phase was loaded as 1, so a toggle at minute 0 is aligned.
        pulse(1'b0, 1'b1);
        chk("set_phase_syncError", 32'(bus.syncError), 32'd0);
        // Identical values: no strobe may appear.
        set_pulse(mm, mh);
        chk("same_set_minutePos", 32'(bus.minutePos), 32'd0);
        chk("same_set_hourPos", 32'(bus.hourPos), 32'd18);
        // Hour clamp with a low minute.
        set_pulse(10, 62);
        chk("clamp_hourPos", 32'(bus.hourPos), 32'd59);
        chk("clamp_minutePos", 32'(bus.minutePos), 32'd10);

        // Reset between a tick's sample and its update.
        bus.minuteClock = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_clear();
        #1;
        chk("midrst_minutePos", 32'(bus.minutePos), 32'd0);
        chk("midrst_hourPos", 32'(bus.hourPos), 32'd0);
        chk("midrst_posStrobe", 32'(bus.posStrobe), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("midrst_hold_minutePos", 32'(bus.minutePos), 32'd0);
        end
        bus.minuteClock = 1'b0;
        repeat (3) @(negedge clock);

        // Any expected strobe that never arrived is a miss.
        chk("pending_strobes", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end

endmodule

// File: doc/hand_position_decoder.md
# hand_position_decoder

Consumes the slow timebase signals of the clock buffer, the `minuteClock` tick and the half-hour-toggling `hourClock`, and converts them into analog hand positions for the display drivers. It runs in the fast system clock domain and synchronizes both slow inputs. Outputs are a minute-hand position and an hour-hand position, each 0..59 on a 60-step dial, plus a one-cycle update strobe. The half-hour toggle serves as an alignment reference for the minute hand.

## Interface
Parameters:
- `SUB_STEPS`, default 12: minute ticks per hour-hand step (60 / 5 hour steps per hour).
- `DIAL_STEPS`, default 60: positions per revolution for both hands.

Ports:
- `clock` in 1: system clock. Everything is on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `minuteClock` in 1: asynchronous slow input. Each rising edge means one minute elapsed.
- `hourClock` in 1: asynchronous slow input. Each transition, either polarity, means one half-hour elapsed.
- `setEnable` in 1: synchronous load of hand positions.
- `setMinute` in 6: minute position to load.
- `setHour` in 6: hour position to load.
- `minutePos` out 6: minute hand position, 0..59.
- `hourPos` out 6: hour hand position, 0..59.
- `posStrobe` out 1: high for exactly one cycle after either position changes.
- `syncError` out 1: sticky misalignment flag.

## Operation
- **Input synchronizers.** Each slow input passes through its own 2-flop synchronizer, then a history register.
  - A minute tick is stage2 high with history low.
  - An hour event is stage2 differing from history.
  - An arming flag suppresses all tick and event detection for the first 3 clocks after reset release. This prevents spurious edges when the inputs are high at reset.
- **Minute tick.**
  - `minutePos` increments and wraps 59→0.
  - Internal `hourSub` (0..SUB_STEPS-1) increments.
  - When `hourSub` = SUB_STEPS-1 it clears to 0 and `hourPos` increments, wrapping 59→0.
- **Hour event.**
  - Expected minute position is 30 when the internal `phase` = 0, and 0 when `phase` = 1.
  - `phase` toggles on every hour event.
  - The comparison uses the `minutePos` value after any minute tick applied in the same cycle.
  - On a mismatch, `syncError` is set. It stays set until reset or `setEnable`.
- **Set.** `setEnable` takes priority over ticks and events in the same cycle; those are discarded.
  - Load `minutePos` = min(`setMinute`, 59) and `hourPos` = min(`setHour`, 59).
  - Load `hourSub` = loaded minute mod SUB_STEPS.
  - Set `phase` = 1 if the loaded minute ≥ 30, else 0.
  - Clear `syncError`.
  - Synchronizer and history registers keep running during a set.
- **Strobe.** `posStrobe` is asserted the cycle after a tick, a set, or a resync changes either position. It is not asserted when a set loads identical values.

## Timing
- **Reset values:**
  - `minutePos` = 0, `hourPos` = 0, `posStrobe` = 0, `syncError` = 0.
  - `hourSub` = 0, `phase` = 0, synchronizers and history = 0, arming flag clear.
- **Tick latency.** Suppose `minuteClock` is first sampled high at edge k, with armed already set.
  - Positions update at edge k+2.
  - `posStrobe` is high from edge k+2 to edge k+3.
- **Set latency.** With `setEnable` sampled at edge k, positions update at edge k and `posStrobe` is high from edge k+1 to edge k+2.
- **Minimum input width.** Inputs must be stable for at least 2 clock periods per level. Narrower pulses may be missed, and that is not an error.
- **Reset mid-operation.** All state clears immediately and asynchronously. Re-arming takes 3 clocks.
- **Simultaneous events.** A minute tick and an hour event in the same cycle: the increment is applied first, then the check or resync.

## Configuration
- **Macro `HAND_RESYNC_EN`.** When defined, an hour event with a mismatch does all of the following:
  - sets `syncError`;
  - forces `minutePos` to the expected value (0 or 30);
  - sets `hourSub` = expected mod SUB_STEPS (0 or 6);
  - leaves `hourPos` unchanged;
  - strobes if `minutePos` changed.
- **Without the macro.** A mismatch only sets `syncError`. Positions are never corrected.

## Test plan
- **Reset and arming.**
  - Stimulus: hold `minuteClock` = 1 through reset release.
  - Required: no tick, `minutePos` = 0, `posStrobe` = 0 for 10 cycles. The first real rising edge afterwards gives `minutePos` = 1 with a one-cycle strobe at k+2.
- **Hour-hand carry and dial wrap.**
  - Stimulus: from reset, apply 720 minute ticks.
  - Required: `hourPos` steps every 12 ticks. Final `minutePos` = 0, `hourPos` = 0. `hourPos` = 5 after tick 60.
- **Aligned hour events.**
  - Stimulus: toggle `hourClock` in the same cycle as tick 30 and again at tick 60.
  - Required: `syncError` stays 0 and `phase` returns to 0.
- **Misaligned hour event.**
  - Stimulus: toggle `hourClock` after tick 28.
  - Required: `syncError` = 1. With `HAND_RESYNC_EN`, `minutePos` = 30, a strobe, and the next hour step occurs after 6 further ticks. Without the macro, `minutePos` stays 28.
- **Set priority and clamp.**
  - Stimulus: pulse `setEnable` with `setMinute` = 63 and `setHour` = 17 in the same cycle as a minute tick.
  - Required: `minutePos` = 59, `hourPos` = 17, the tick is discarded, `syncError` is cleared, `phase` = 1. The next tick gives `minutePos` = 0.
- **Reset mid-stream.**
  - Stimulus: assert `reset` between a tick's sample and its update.
  - Required: outputs are 0 immediately and no update follows.
